// File: rtl/shreg_pkg.sv
// Shared types for the universal shift register.
// Build option: define SHREG_ROTATE_EN to enable rotate on SHL/SHR.
package shreg_pkg;

  // Operation select carried on the 2-bit mode port.
  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHL  = 2'b01,
    MODE_SHR  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_t;

endpackage

// File: rtl/shreg_fill_ctr.sv
// Saturating 0..WIDTH counter of valid bits held in the shift register.
// Priority: clr, then set_full, then inc. Never wraps past WIDTH.
module shreg_fill_ctr
  import shreg_pkg::*;
#(
  parameter  int WIDTH = 6,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  input  logic          set_full,
  output logic [CW-1:0] fill,
  output logic          full
);

  localparam logic [CW-1:0] FILL_MAX     = CW'(WIDTH);
  localparam logic [CW:0]   FILL_MAX_EXT = (CW + 1)'(WIDTH);

  // Increment one bit wider than the counter so the compare can never see a wrapped value.
  logic [CW:0] inc_ext;
  assign inc_ext = {1'b0, fill} + (CW + 1)'(1);

  // Counter state update with saturation at WIDTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      fill <= '0;
    end else if (clr) begin
      fill <= '0;
    end else if (set_full) begin
      fill <= FILL_MAX;
    end else if (inc) begin
      fill <= (inc_ext >= FILL_MAX_EXT) ? FILL_MAX : inc_ext[CW-1:0];
    end
  end

  assign full = (fill == FILL_MAX);

endmodule

// File: rtl/shreg_univ.sv
// Universal shift register: hold, shift left/right, parallel load, sync clear,
// plus a fill counter of bits entered since the last clear.
// Build option: SHREG_ROTATE_EN makes rot=1 recirculate the outgoing end bit
// on SHL/SHR (fill unchanged); without it rot is ignored.
module shreg_univ
  import shreg_pkg::*;
#(
  parameter  int WIDTH = 6,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [1:0]       mode,
  input  logic             sin_lo,
  input  logic             sin_hi,
  input  logic             rot,
  input  logic [WIDTH-1:0] pdata,
  output logic [WIDTH-1:0] q,
  output logic             sout_hi,
  output logic             sout_lo,
  output logic [CW-1:0]    fill,
  output logic             full
);

  mode_t            op;
  logic             rot_act;
  logic             feed_lo;
  logic             feed_hi;
  logic [WIDTH-1:0] q_nxt;
  logic             fill_inc;
  logic             fill_set;

  assign op = mode_t'(mode);

`ifdef SHREG_ROTATE_EN
  assign rot_act = rot;
`else
  logic unused_rot;
  assign unused_rot = rot;
  assign rot_act    = 1'b0;
`endif

  // Bit entering the vacated end: the opposite end bit when rotating, else the serial input.
  assign feed_lo = rot_act ? q[WIDTH-1] : sin_lo;
  assign feed_hi = rot_act ? q[0]       : sin_hi;

  // Mode decode: next register value and fill counter requests (en=0 means hold).
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    q_nxt    = q;
    fill_inc = 1'b0;
    fill_set = 1'b0;
    if (en) begin
      unique case (op)
        MODE_SHL: begin
          q_nxt    = {q[WIDTH-2:0], feed_lo};
          fill_inc = !rot_act;
        end
        MODE_SHR: begin
          q_nxt    = {feed_hi, q[WIDTH-1:1]};
          fill_inc = !rot_act;
        end
        MODE_LOAD: begin
          q_nxt    = pdata;
          fill_set = 1'b1;
        end
        default: begin
          q_nxt = q;
        end
      endcase
    end
  end

  // Data register; clear overrides everything including en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else begin
      q <= q_nxt;
    end
  end

  shreg_fill_ctr #(.WIDTH(WIDTH)) u_fill_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .inc      (fill_inc),
    .set_full (fill_set),
    .fill     (fill),
    .full     (full)
  );

  assign sout_hi = q[WIDTH-1];
  assign sout_lo = q[0];

endmodule

// File: tb/tb_shreg_univ.sv
// Self-checking bench for shreg_univ (WIDTH=6): directed vector table,
// asynchronous reset check, then random stimulus against a reference model.
module tb_shreg_univ;

  localparam int W  = 6;
  localparam int CW = $clog2(W + 1);
`ifdef SHREG_ROTATE_EN
  localparam bit ROT_BUILD = 1'b1;
`else
  localparam bit ROT_BUILD = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          en;
  logic          clr;
  logic [1:0]    mode;
  logic          sin_lo;
  logic          sin_hi;
  logic          rot;
  logic [W-1:0]  pdata;
  logic [W-1:0]  q;
  logic          sout_hi;
  logic          sout_lo;
  logic [CW-1:0] fill;
  logic          full;

  int errors = 0;
  int checks = 0;

  shreg_univ #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .clr     (clr),
    .mode    (mode),
    .sin_lo  (sin_lo),
    .sin_hi  (sin_hi),
    .rot     (rot),
    .pdata   (pdata),
    .q       (q),
    .sout_hi (sout_hi),
    .sout_lo (sout_lo),
    .fill    (fill),
    .full    (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       clr;
    logic       en;
    logic [1:0] mode;
    logic       sl;
    logic       sh;
    logic       rot;
    logic [5:0] pd;
    int         eq;
    int         ef;
  } vec_t;

  vec_t tab[$];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input string name, input logic c, input logic e, input logic [1:0] m,
                     input logic sl, input logic sh, input logic r, input logic [5:0] pd,
                     input int eq, input int ef);
    vec_t v;
    v.name = name; v.clr = c; v.en = e; v.mode = m; v.sl = sl; v.sh = sh;
    v.rot = r; v.pd = pd; v.eq = eq; v.ef = ef;
    tab.push_back(v);
  endtask

  task automatic drive(input logic c, input logic e, input logic [1:0] m, input logic sl,
                       input logic sh, input logic r, input logic [5:0] pd);
    clr = c; en = e; mode = m; sin_lo = sl; sin_hi = sh; rot = r; pdata = pd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string name, input int eq, input int ef);
    check({name, ".q"},       q,       eq);
    check({name, ".fill"},    fill,    ef);
    check({name, ".full"},    full,    (ef == W));
    check({name, ".sout_hi"}, sout_hi, (eq >> (W - 1)) & 1);
    check({name, ".sout_lo"}, sout_lo, eq & 1);
  endtask

  // Reference model: plain integer arithmetic on the register value.
  int mq, mf;
  task automatic model(input logic c, input logic e, input logic [1:0] m, input logic sl,
                       input logic sh, input logic r, input logic [5:0] pd);
    int mask;
    mask = (1 << W) - 1;
    if (c) begin
      mq = 0; mf = 0;
    end else if (e) begin
      case (m)
        2'd1: begin
          if (ROT_BUILD && r) mq = ((mq << 1) | (mq >> (W - 1))) & mask;
          else begin
            mq = ((mq << 1) | int'(sl)) & mask;
            mf = (mf + 1 > W) ? W : mf + 1;
          end
        end
        2'd2: begin
          if (ROT_BUILD && r) mq = (mq >> 1) | ((mq & 1) << (W - 1));
          else begin
            mq = (mq >> 1) | (int'(sh) << (W - 1));
            mf = (mf + 1 > W) ? W : mf + 1;
          end
        end
        2'd3: begin
          mq = int'(pd); mf = W;
        end
        default: ;
      endcase
    end
  endtask

  initial begin
    logic c, e, sl, sh, r;
    logic [1:0] m;
    logic [5:0] pd;

    rst_n = 1'b0;
    drive(0, 0, 2'b00, 0, 0, 0, 6'h00);
    #2;
    check_state("reset_init", 0, 0);
    #6 rst_n = 1'b1;

    // Directed table: serial fill, saturation, load/shift right, priority, hold.
    add("shl1", 0, 1, 2'b01, 1, 0, 0, 0, 6'b000001, 1);
    add("shl2", 0, 1, 2'b01, 0, 0, 0, 0, 6'b000010, 2);
    add("shl3", 0, 1, 2'b01, 1, 0, 0, 0, 6'b000101, 3);
    add("shl4", 0, 1, 2'b01, 1, 0, 0, 0, 6'b001011, 4);
    add("shl5", 0, 1, 2'b01, 0, 0, 0, 0, 6'b010110, 5);
    add("shl6", 0, 1, 2'b01, 1, 0, 0, 0, 6'b101101, 6);
    add("shl7_sat", 0, 1, 2'b01, 0, 0, 0, 0, 6'b011010, 6);
    add("load3c", 0, 1, 2'b11, 0, 0, 0, 6'h3C, 6'h3C, 6);
    add("shr_in1", 0, 1, 2'b10, 0, 1, 0, 0, 6'h3E, 6);
    add("clr_vs_load", 1, 1, 2'b11, 1, 1, 1, 6'h3F, 0, 0);
    add("shl_after_clr", 0, 1, 2'b01, 1, 0, 0, 0, 6'b000001, 1);
    add("hold_en0_shl", 0, 0, 2'b01, 1, 1, 0, 0, 6'b000001, 1);
    add("hold_en0_load", 0, 0, 2'b11, 1, 1, 0, 6'h2A, 6'b000001, 1);
    add("hold_mode", 0, 1, 2'b00, 1, 1, 1, 6'h15, 6'b000001, 1);
    add("clr_en0", 1, 0, 2'b10, 1, 1, 0, 6'h15, 0, 0);
    add("shr_seed", 0, 1, 2'b10, 0, 1, 0, 0, 6'b100000, 1);
`ifdef SHREG_ROTATE_EN
    add("rot_shl", 0, 1, 2'b01, 0, 0, 1, 0, 6'b000001, 1);
    add("rot_shr", 0, 1, 2'b10, 0, 0, 1, 0, 6'b100000, 1);
    add("rot_load", 0, 1, 2'b11, 0, 0, 1, 6'h21, 6'h21, 6);
`else
    add("rot_shl", 0, 1, 2'b01, 0, 0, 1, 0, 6'b000000, 2);
    add("rot_shr", 0, 1, 2'b10, 0, 0, 1, 0, 6'b000000, 3);
    add("rot_load", 0, 1, 2'b11, 0, 0, 1, 6'h21, 6'h21, 6);
`endif

    for (int i = 0; i < tab.size(); i++) begin
      drive(tab[i].clr, tab[i].en, tab[i].mode, tab[i].sl, tab[i].sh, tab[i].rot, tab[i].pd);
      step();
      check_state(tab[i].name, tab[i].eq, tab[i].ef);
    end

    // Asynchronous reset mid-cycle with q=2A, no clock edge required.
    drive(0, 1, 2'b11, 0, 0, 0, 6'h2A);
    step();
    check_state("load2a", 6'h2A, 6);
    drive(0, 0, 2'b00, 0, 0, 0, 6'h00);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_state("async_rst", 0, 0);
    #2 rst_n = 1'b1;
    // First edge after release performs a normal operation.
    drive(0, 1, 2'b01, 1, 0, 0, 6'h00);
    step();
    check_state("post_rst_shl", 6'b000001, 1);

    // Random phase from a clean reset against the reference model.
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    mq = 0; mf = 0;
    for (int i = 0; i < 400; i++) begin
      c  = ($urandom_range(0, 19) == 0);
      e  = ($urandom_range(0, 7) != 0);
      m  = 2'($urandom_range(0, 3));
      if (m == 2'b11 && $urandom_range(0, 2) != 0) m = 2'($urandom_range(1, 2));
      sl = 1'($urandom);
      sh = 1'($urandom);
      r  = 1'($urandom);
      pd = 6'($urandom);
      drive(c, e, m, sl, sh, r, pd);
      model(c, e, m, sl, sh, r, pd);
      step();
      check_state($sformatf("rand%0d", i), mq, mf);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
